iref_seq: RTL and testbench
===========================

# iref_seq

Multi-channel power-up sequencer for the emulated current reference generators. For each channel it drives the `pd` and `charge` controls: `charge` is released a programmable number of cycles after `pd` goes low, and a settled `ready` flag is raised once the reference is stable. It sits between the radio/ADC power manager and the iref instances and replaces per-block ad hoc pd/charge wiring.

## Interface
- `N_CH`, 4: number of independent reference channels.
- `CNT_W`, 8: width of the delay counters and delay inputs.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `en` input N_CH: per-channel enable request, level-sensitive.
- `charge_cycles` input CNT_W: cycles `charge` stays high after `pd` falls. Shared by all channels and sampled when a channel leaves OFF.
- `settle_cycles` input CNT_W: cycles from the `charge` fall to `ready`. Shared by all channels and sampled at the same point.
- `iref_pd` output N_CH: power-down control per channel, 1 = powered down.
- `iref_charge` output N_CH: fast-charge control per channel, 1 = charging.
- `iref_ready` output N_CH: reference settled.
- `busy` output 1: OR of all channels in CHARGE or SETTLE.

## Operation
- Each channel has an independent FSM with states OFF, CHARGE, SETTLE and READY. A WAIT state exists only with the configuration macro (see Configuration).
- Outputs per state (pd/charge/ready):
  - OFF: 1/1/0
  - WAIT: 1/1/0
  - CHARGE: 0/1/0
  - SETTLE: 0/0/0
  - READY: 0/0/1
- OFF with `en`=1 goes to CHARGE. The delay counter is loaded with max(`charge_cycles`,1), and `settle_cycles` is latched.
- CHARGE: the counter decrements every cycle. When the counter reaches 1, the next state is SETTLE, or READY if the latched settle value is 0.
- SETTLE runs for the latched settle value, then goes to READY.
- READY is held while `en`=1.
- `en`=0 in any state forces OFF on the next edge. Any in-progress count is aborted.
- If `en` is re-asserted, the full sequence restarts from CHARGE. Delays are never resumed.
- Changes to `charge_cycles` or `settle_cycles` while a channel is sequencing do not affect that channel.
- Counters are CNT_W bits wide and never wrap. 0 is handled as stated above.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Reset values: `iref_pd`=all 1, `iref_charge`=all 1, `iref_ready`=0, `busy`=0, all FSMs in OFF.
- `en` sampled high at edge t gives `pd`=0 from t+1.
- `charge` falls at t+1+max(C,1).
- `ready` rises at t+1+max(C,1)+S.
- `en` sampled low at edge t gives `pd`=1, `charge`=1 and `ready`=0 from t+1, regardless of state.
- `rst` overrides `en` in the same cycle.

## Configuration
- Macro: `IREF_SEQ_STAGGER_EN`.
- Defined: at most one channel is in CHARGE at a time, which limits inrush current.
  - A channel requesting to leave OFF goes to WAIT.
  - A WAIT channel is granted CHARGE when no channel is in CHARGE. The lowest-index waiting channel wins.
  - The grant takes effect on the edge after the current CHARGE channel exits.
  - Dropping `en` in WAIT returns the channel to OFF.
  - `busy` also covers WAIT.
- Undefined: the WAIT state and the arbiter are absent, and channels sequence concurrently.

## Structure
- Package `iref_seq_pkg` holds:
  - the state enum `iref_state_t` (OFF, WAIT, CHARGE, SETTLE, READY);
  - the per-state output encoding constants.
- Sub-module `iref_seq_ch` holds one channel: FSM, counter and latched settle value. It has a `grant` input, which is tied to 1 when the macro is undefined.
- The top level instantiates N_CH copies of `iref_seq_ch` and contains the optional fixed-priority arbiter plus the `busy` reduction.

## Test plan
- Reset: assert `rst` for 3 cycles with `en`=all 1 -> outputs hold pd=F, charge=F, ready=0 and busy=0 throughout. The sequence starts on the first cycle after release.
- Basic sequence, C=5, S=3, `en[0]` rises at edge 10 -> pd falls at 11, charge falls at 16, ready rises at 19. `busy`=1 during cycles 11-18.
- Zero delays, C=0, S=0 -> charge falls 1 cycle after pd, and ready rises in the same cycle as the charge fall.
- Abort: drop `en[1]` 2 cycles into SETTLE -> pd=1 and charge=1 on the next edge. Re-enable with C changed from 5 to 2 -> the full sequence runs using C=2.
- Mid-run reconfiguration: change C from 5 to 9 during CHARGE -> the running channel still releases charge after 5 cycles.
- With `IREF_SEQ_STAGGER_EN`, enable channels 2, 0 and 3 together, C=4 -> charge phases are serialized 0, 2, 3. No two `iref_charge` bits are ever both 1 while both of those channels have pd=0.

Source files
------------

// File: rtl/iref_seq_pkg.sv
// iref_seq_pkg: shared state encoding and per-state output decode for the iref power-up sequencer
package iref_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAIT,
        ST_CHARGE,
        ST_SETTLE,
        ST_READY
    } iref_state_t;

    // Per-state output encoding, packed as {pd, charge, ready}
    localparam logic [2:0] OUT_OFF    = 3'b110;
    localparam logic [2:0] OUT_WAIT   = 3'b110;
    localparam logic [2:0] OUT_CHARGE = 3'b010;
    localparam logic [2:0] OUT_SETTLE = 3'b000;
    localparam logic [2:0] OUT_READY  = 3'b001;

    function automatic logic [2:0] state_out(input iref_state_t s);
        return (s == ST_WAIT)   ? OUT_WAIT   :
               (s == ST_CHARGE) ? OUT_CHARGE :
               (s == ST_SETTLE) ? OUT_SETTLE :
               (s == ST_READY)  ? OUT_READY  : OUT_OFF;
    endfunction

    function automatic logic state_busy(input iref_state_t s);
        return (s == ST_WAIT) || (s == ST_CHARGE) || (s == ST_SETTLE);
    endfunction

endpackage

// File: rtl/iref_seq_ch.sv
// iref_seq_ch: one sequencer channel (FSM, delay counter, latched settle value)
//   clk, rst             : clock, synchronous active-high reset
//   en                   : level-sensitive enable request
//   grant                : permission to leave WAIT (tied high when IREF_SEQ_STAGGER_EN is undefined)
//   charge_cycles        : charge delay, sampled when leaving OFF
//   settle_cycles        : settle delay, sampled when leaving OFF
//   pd, charge, ready    : decoded from the state register only
//   state                : current state, used by the top for busy and arbitration
// Macro IREF_SEQ_STAGGER_EN: leaving OFF passes through WAIT until granted.
module iref_seq_ch
    import iref_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             grant,
    input  logic [CNT_W-1:0] charge_cycles,
    input  logic [CNT_W-1:0] settle_cycles,
    output logic             pd,
    output logic             charge,
    output logic             ready,
    output iref_state_t      state
);

    iref_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] set_q, set_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        set_d   = set_q;
        if (!en) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
`ifdef IREF_SEQ_STAGGER_EN
                    state_d = ST_WAIT;
`else
                    state_d = ST_CHARGE;
`endif
                    // Counter is loaded here and simply held while waiting for a grant
                    cnt_d   = (charge_cycles == '0) ? CNT_W'(1) : charge_cycles;
                    set_d   = settle_cycles;
                end
                ST_WAIT: state_d = grant ? ST_CHARGE : ST_WAIT;
                ST_CHARGE: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = (set_q == '0) ? ST_READY : ST_SETTLE;
                        cnt_d   = set_q;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == CNT_W'(1)) state_d = ST_READY;
                    else cnt_d = cnt_q - CNT_W'(1);
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
        end
    end

    assign {pd, charge, ready} = state_out(state_q);
    assign state = state_q;

endmodule

// File: rtl/iref_seq.sv
// iref_seq: multi-channel power-up sequencer for the emulated current reference generators
//   clk, rst       : clock, synchronous active-high reset
//   en             : per-channel enable request
//   charge_cycles  : cycles charge stays high after pd falls (shared)
//   settle_cycles  : cycles from charge fall to ready (shared)
//   iref_pd        : per-channel power-down, 1 = powered down
//   iref_charge    : per-channel fast-charge, 1 = charging
//   iref_ready     : per-channel reference settled
//   busy           : any channel sequencing
// Macro IREF_SEQ_STAGGER_EN: serialize charge phases with a fixed-priority arbiter.
module iref_seq
    import iref_seq_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic [CNT_W-1:0] charge_cycles,
    input  logic [CNT_W-1:0] settle_cycles,
    output logic [N_CH-1:0]  iref_pd,
    output logic [N_CH-1:0]  iref_charge,
    output logic [N_CH-1:0]  iref_ready,
    output logic             busy
);

    iref_state_t     st [N_CH];
    logic [N_CH-1:0] grant;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        iref_seq_ch #(.CNT_W(CNT_W)) u_ch (
            .clk           (clk),
            .rst           (rst),
            .en            (en[g]),
            .grant         (grant[g]),
            .charge_cycles (charge_cycles),
            .settle_cycles (settle_cycles),
            .pd            (iref_pd[g]),
            .charge        (iref_charge[g]),
            .ready         (iref_ready[g]),
            .state         (st[g])
        );
    end

`ifdef IREF_SEQ_STAGGER_EN
    // Grant goes to the lowest-index waiter only when nobody is charging, so the
    // next channel enters CHARGE on the edge after the current one leaves it.
    logic taken;
    always_comb begin
        grant = '0;
        taken = 1'b0;
        for (int i = 0; i < N_CH; i++) taken = taken | (st[i] == ST_CHARGE);
        for (int i = 0; i < N_CH; i++) begin
            if (!taken && st[i] == ST_WAIT && en[i]) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
    end
`else
    assign grant = '1;
`endif

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < N_CH; i++) busy = busy | state_busy(st[i]);
    end

endmodule

// File: tb/tb_iref_seq.sv
// tb_iref_seq: directed self-checking bench for iref_seq
module tb_iref_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic [7:0] charge_cycles;
    logic [7:0] settle_cycles;
    logic [3:0] iref_pd;
    logic [3:0] iref_charge;
    logic [3:0] iref_ready;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    iref_seq #(.N_CH(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .charge_cycles (charge_cycles),
        .settle_cycles (settle_cycles),
        .iref_pd       (iref_pd),
        .iref_charge   (iref_charge),
        .iref_ready    (iref_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pd"}, 32'(iref_pd), 32'hF);
        chk({tag, "_chg"}, 32'(iref_charge), 32'hF);
        chk({tag, "_rdy"}, 32'(iref_ready), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // Enables channel ch and checks n edges; after the first edge C is changed to c_mid.
    // Edge j=1 samples en: pd low from j=1, charge low from j=m+1, ready from j=m+1+s.
    task automatic run_seq(input int ch, input int c, input int s, input int c_mid, input int n);
        int m;
        m = (c == 0) ? 1 : c;
        charge_cycles = 8'(c);
        settle_cycles = 8'(s);
        en[ch] = 1'b1;
        for (int j = 1; j <= n; j++) begin
            step();
            if (j == 1) charge_cycles = 8'(c_mid);
            chk($sformatf("ch%0d_c%0d_s%0d_j%0d", ch, c, s, j),
                32'({iref_pd[ch], iref_charge[ch], iref_ready[ch]}),
                32'({1'b0, j <= m, j >= m + 1 + s}));
            chk($sformatf("pdvec_ch%0d_j%0d", ch, j), 32'(iref_pd), 32'(4'hF & ~(4'b1 << ch)));
            chk($sformatf("busy_ch%0d_j%0d", ch, j), 32'(busy), 32'(j < m + 1 + s));
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 4'hF;
        charge_cycles = 8'd5;
        settle_cycles = 8'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle($sformatf("reset%0d", i));
        end
        rst = 1'b0;
`ifdef IREF_SEQ_STAGGER_EN
        en = 4'b0000;
        step();
        chk_idle("stag_pre");
        charge_cycles = 8'd4;
        settle_cycles = 8'd2;
        en = 4'b1101;
        for (int j = 1; j <= 20; j++) begin
            logic [3:0] exp_act;
            step();
            exp_act = (j >= 2 && j <= 5)   ? 4'b0001 :
                      (j >= 7 && j <= 10)  ? 4'b0100 :
                      (j >= 12 && j <= 15) ? 4'b1000 : 4'b0000;
            chk($sformatf("stag_act_j%0d", j), 32'(~iref_pd & iref_charge), 32'(exp_act));
        end
        chk("stag_ready", 32'(iref_ready), 32'h0000000D);
        chk("stag_busy", 32'(busy), 32'h0);
        en = 4'b0000;
        step();
        chk_idle("stag_off");
`else
        step();
        chk("rel_pd", 32'(iref_pd), 32'h0);
        chk("rel_chg", 32'(iref_charge), 32'hF);
        chk("rel_busy", 32'(busy), 32'h1);
        en = 4'h0;
        step();
        chk_idle("rel_off");
        // Basic sequence with ready held a few extra cycles
        run_seq(0, 5, 3, 5, 12);
        en = 4'h0;
        step();
        chk_idle("basic_off");
        // Zero delays
        run_seq(3, 0, 0, 0, 4);
        en = 4'h0;
        step();
        chk_idle("zero_off");
        // Abort two cycles into SETTLE, then restart with a shorter charge
        run_seq(1, 5, 3, 5, 7);
        en = 4'h0;
        step();
        chk_idle("abort");
        run_seq(1, 2, 3, 2, 8);
        en = 4'h0;
        step();
        chk_idle("restart_off");
        // Reconfiguration during CHARGE must not affect the running channel
        run_seq(2, 5, 2, 9, 10);
        en = 4'h0;
        step();
        chk_idle("reconf_off");
        // Long settle with charge=1 boundary
        run_seq(0, 1, 6, 1, 9);
        en = 4'h0;
        step();
        chk_idle("long_off");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
